// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hit lookup in front of a
// word-serial backing memory, with line refill over a req/ack handshake.
module icache_dm #(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 4
) (
   input  logic        i_clk,
   input  logic        i_n_rst,
   input  logic        i_req_valid,
   input  logic [31:0] i_req_pc,
   input  logic        i_flush,
   output logic [31:0] o_instr,
   output logic        o_hit,
   output logic        o_stall,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   output logic [31:0] o_n_hit,
   output logic [31:0] o_n_miss
);

   localparam int unsigned WOFF_W  = $clog2(WORDS);
   localparam int unsigned IDX_W   = $clog2(LINES);
   localparam int unsigned LINE_W  = 30 - WOFF_W;       // line address width
   localparam int unsigned TAG_W   = LINE_W - IDX_W;
   localparam int unsigned TAG_LSB = 2 + WOFF_W + IDX_W;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_REFILL = 1'b1;

   logic [0:0]        r_state;
   logic [WOFF_W-1:0] r_beat;
   logic [LINE_W-1:0] r_base_hi;     // latched miss line address (index + tag)
   logic [LINES-1:0]  r_valid;
   logic              r_flush_pending;
   logic [31:0]       r_n_hit;
   logic [31:0]       r_n_miss;

   logic [TAG_W-1:0]  r_tag_arr [LINES];
   logic [31:0]       r_data    [LINES][WORDS];

   logic [WOFF_W-1:0] w_req_word;
   logic [IDX_W-1:0]  w_req_idx;
   logic [TAG_W-1:0]  w_req_tag;
   logic [IDX_W-1:0]  w_fill_idx;
   logic [TAG_W-1:0]  w_fill_tag;
   logic              w_idle;
   logic              w_refill;
   logic              w_hit;
   logic              w_miss_start;
   logic              w_beat_ack;
   logic              w_last_beat;
   logic              w_fill_done;
   logic              w_unused_pc;

   assign w_req_word  = i_req_pc[2 +: WOFF_W];
   assign w_req_idx   = i_req_pc[2 + WOFF_W +: IDX_W];
   assign w_req_tag   = i_req_pc[31:TAG_LSB];
   assign w_fill_idx  = r_base_hi[IDX_W-1:0];
   assign w_fill_tag  = r_base_hi[LINE_W-1:IDX_W];
   assign w_unused_pc = ^i_req_pc[1:0];

   assign w_idle       = (r_state == ST_IDLE);
   assign w_refill     = (r_state == ST_REFILL);
   assign w_hit        = w_idle & i_req_valid & r_valid[w_req_idx]
                         & (r_tag_arr[w_req_idx] == w_req_tag);
   // A flush suppresses the refill; the miss keeps stalling and retries.
   assign w_miss_start = w_idle & i_req_valid & ~w_hit & ~i_flush;
   assign w_beat_ack   = w_refill & i_mem_ack;
   assign w_last_beat  = (r_beat == WOFF_W'(WORDS - 1));
   assign w_fill_done  = w_beat_ack & w_last_beat;

   // Lookup and memory-side outputs
   always_comb begin
      o_hit      = w_hit;
      o_instr    = w_hit ? r_data[w_req_idx][w_req_word] : 32'h0;
      o_stall    = w_refill | (i_req_valid & ~w_hit);
      o_mem_req  = w_refill;
      o_mem_addr = w_refill ? {r_base_hi, r_beat, 2'b00} : 32'h0;
      o_n_hit    = r_n_hit;
      o_n_miss   = r_n_miss;
   end

   // Control state, valid bits and performance counters
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state         <= ST_IDLE;
         r_beat          <= '0;
         r_base_hi       <= '0;
         r_valid         <= '0;
         r_flush_pending <= 1'b0;
         r_n_hit         <= 32'h0;
         r_n_miss        <= 32'h0;
      end else begin
         r_n_hit <= r_n_hit + 32'(w_hit);
         if (i_flush) begin
            r_valid <= '0;
            if (w_refill && !w_fill_done) begin
               r_flush_pending <= 1'b1;
            end
         end
         if (w_miss_start) begin
            r_state   <= ST_REFILL;
            r_base_hi <= i_req_pc[31:2+WOFF_W];
            r_beat    <= '0;
            r_n_miss  <= r_n_miss + 32'h1;
         end
         if (w_beat_ack) begin
            r_beat <= r_beat + WOFF_W'(1);
         end
         if (w_fill_done) begin
            // A flush seen at any point during the refill leaves the line invalid.
            r_valid[w_fill_idx] <= ~(r_flush_pending | i_flush);
            r_flush_pending     <= 1'b0;
            r_state             <= ST_IDLE;
         end
      end
   end

   // Data and tag arrays are not reset; only the valid bits qualify them
   always_ff @(posedge i_clk) begin
      if (w_beat_ack) begin
         r_data[w_fill_idx][r_beat] <= i_mem_rdata;
      end
      if (w_fill_done) begin
         r_tag_arr[w_fill_idx] <= w_fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: fetch stimulus pushes expected instructions and refill
// addresses into queues; monitors pop and compare as the cache presents them.
module tb_icache_dm;

   localparam int unsigned LINES = 16;
   localparam int unsigned WORDS = 4;

   logic        clk;
   logic        n_rst;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        flush;
   logic [31:0] instr;
   logic        hit;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] n_hit;
   logic [31:0] n_miss;

   int n_checks = 0;
   int n_errors = 0;
   int ack_period = 1;
   int wcnt = 0;

   logic [31:0] exp_instr_q [$];
   logic [31:0] exp_addr_q  [$];

   icache_dm #(.LINES(LINES), .WORDS(WORDS)) u_dut (
      .i_clk       (clk),
      .i_n_rst     (n_rst),
      .i_req_valid (req_valid),
      .i_req_pc    (req_pc),
      .i_flush     (flush),
      .o_instr     (instr),
      .o_hit       (hit),
      .o_stall     (stall),
      .o_mem_req   (mem_req),
      .o_mem_addr  (mem_addr),
      .i_mem_ack   (mem_ack),
      .i_mem_rdata (mem_rdata),
      .o_n_hit     (n_hit),
      .o_n_miss    (n_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory contents: upper half is the inverted address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign mem_rdata = mem_word(mem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory responder: ack once every ack_period cycles of mem_req
   always @(posedge clk) begin
      #1;
      if (!n_rst || !mem_req) begin
         wcnt    = 0;
         mem_ack = 1'b0;
      end else begin
         wcnt++;
         if (wcnt >= ack_period) begin
            mem_ack = 1'b1;
            wcnt    = 0;
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   // Instruction monitor
   always @(negedge clk) begin
      if (n_rst && hit) begin
         if (exp_instr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL instr_unexpected: got hit with 0x%08h expected no hit", instr);
         end else begin
            check("instr", instr, exp_instr_q.pop_front());
            check("stall_on_hit", {31'h0, stall}, 32'h0);
         end
      end
   end

   // Refill address monitor and address-hold check
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   always @(negedge clk) begin
      if (n_rst && mem_req) begin
         if (prev_req && !prev_ack) begin
            check("mem_addr_hold", mem_addr, prev_addr);
         end
         if (mem_ack) begin
            if (exp_addr_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL mem_addr_unexpected: got 0x%08h expected no request", mem_addr);
            end else begin
               check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
         end
      end
      prev_req  = n_rst & mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
   end

   // Issue one fetch and hold it until the hit; called just after a rising edge
   task automatic fetch(input logic [31:0] pc, input int exp_stalls, input int n_fills);
      int stalls;
      bit got;
      logic [31:0] base;
      base = pc & ~32'(WORDS * 4 - 1);
      for (int f = 0; f < n_fills; f++) begin
         for (int w = 0; w < int'(WORDS); w++) begin
            exp_addr_q.push_back(base + 32'(4 * w));
         end
      end
      exp_instr_q.push_back(mem_word({pc[31:2], 2'b00}));
      req_valid = 1'b1;
      req_pc    = pc;
      stalls    = 0;
      got       = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         if (hit) got = 1'b1;
         else if (stall) stalls++;
      end
      check($sformatf("fetch_hit_%08h", pc), {31'h0, got}, 32'h1);
      check($sformatf("stall_cycles_%08h", pc), stalls, exp_stalls);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic check_counts(input string name, input int eh, input int em);
      check({name, "_n_hit"}, n_hit, eh);
      check({name, "_n_miss"}, n_miss, em);
   endtask

   initial begin
      n_rst     = 1'b0;
      req_valid = 1'b0;
      req_pc    = 32'h0;
      flush     = 1'b0;
      mem_ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hit", {31'h0, hit}, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check_counts("rst", 0, 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss, then warm hits on the same line
      fetch(32'h00, 5, 1);
      check_counts("cold", 1, 1);
      fetch(32'h04, 0, 0);
      fetch(32'h08, 0, 0);
      fetch(32'h0C, 0, 0);
      check_counts("warm", 4, 1);

      // Conflict on index 0
      fetch(32'h100, 5, 1);
      fetch(32'h104, 0, 0);
      fetch(32'h00, 5, 1);
      check_counts("conflict", 7, 3);

      // Wait states: ack every third cycle
      ack_period = 3;
      fetch(32'h40, 13, 1);
      ack_period = 1;
      fetch(32'h44, 0, 0);
      fetch(32'h48, 0, 0);
      fetch(32'h4C, 0, 0);
      check_counts("wait", 11, 4);

      // Flush in IDLE invalidates both filled lines
      fetch(32'h10, 5, 1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      fetch(32'h00, 5, 1);
      fetch(32'h10, 5, 1);
      check_counts("flush_idle", 14, 7);

      // Flush during refill: fill completes, line stays invalid, refetch refills
      fork
         fetch(32'h20, 10, 2);
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
         end
      join
      check_counts("flush_refill", 15, 9);

      // Reset in the middle of a refill, after two acks
      exp_addr_q.push_back(32'h30);
      exp_addr_q.push_back(32'h34);
      req_valid = 1'b1;
      req_pc    = 32'h30;
      @(negedge clk);
      check("rrst_miss_stall", {31'h0, stall}, 32'h1);
      repeat (3) @(posedge clk);
      #3;
      check("rrst_req_before", {31'h0, mem_req}, 32'h1);
      n_rst     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rrst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rrst_mem_addr", mem_addr, 32'h0);
      check("rrst_stall", {31'h0, stall}, 32'h0);
      check_counts("rrst", 0, 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      fetch(32'h30, 5, 1);
      check_counts("after_rrst", 1, 1);

      repeat (2) @(posedge clk);
      check("instr_q_empty", exp_instr_q.size(), 0);
      check("addr_q_empty", exp_addr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
